// File: rtl/sync_data_ram_pkg.sv
// Shared types and width helpers for the clocked load/store data memory.
// The state enum is also exported through the top-level debug port.
package sync_data_ram_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } ram_state_t;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

    // Number of byte-offset bits below the word index.
    function automatic int off_w(input int data_w);
        return (data_w <= 8) ? 0 : $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/sync_data_ram_array.sv
// DEPTH x DATA_W word storage with a byte-strobe write port and a registered read port.
// Contents and the read register are intentionally not reset.
module sync_data_ram_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [STRB_W-1:0] i_wstrb,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // The read register only loads on a read, so it holds through WAIT/RESP.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_data_ram.sv
// Valid/ready data memory for the core's load/store path: one outstanding transaction,
// byte-strobe writes, READ_LAT-cycle response, fault reporting and optional zero-fill.
module sync_data_ram
    import sync_data_ram_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 256,
    parameter int ADDR_W    = 32,
    parameter int READ_LAT  = 1,
    parameter int INIT_ZERO = 1,
    localparam int STRB_W   = strb_w(DATA_W)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [STRB_W-1:0] i_req_wstrb,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output ram_state_t        o_dbg_state
);

    // Handshake: a request transfers on a rising edge where i_req_valid && o_req_ready;
    // a response transfers where o_rsp_valid && i_rsp_ready. Unaccepted inputs are ignored.

    localparam int OFF   = off_w(DATA_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << OFF) - 64'd1);

    ram_state_t        r_state;
    ram_state_t        w_state_nxt;
    logic [IDX_W-1:0]  r_init_idx;
    logic [1:0]        r_lat_cnt;
    logic              r_we;
    logic              r_err;

    logic [ADDR_W-1:0] w_word;
    logic              w_fault;
    logic              w_accept;
    logic              w_arr_we;
    logic              w_arr_re;
    logic [IDX_W-1:0]  w_arr_idx;
    logic [STRB_W-1:0] w_arr_strb;
    logic [DATA_W-1:0] w_arr_wdata;
    logic [DATA_W-1:0] w_arr_rdata;

    assign w_word   = i_req_addr >> OFF;
    // DEPTH is a power of two, so any set bit above the index is out of range.
    assign w_fault  = (|(i_req_addr & ALIGN_MASK)) || (|w_word[ADDR_W-1:IDX_W]);
    assign w_accept = i_req_valid && o_req_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (r_init_idx == IDX_W'(DEPTH - 1)) w_state_nxt = ST_IDLE;
            ST_IDLE: if (w_accept) w_state_nxt = (READ_LAT == 1) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (r_lat_cnt == 2'd0) w_state_nxt = ST_RESP;
            ST_RESP: if (i_rsp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= (INIT_ZERO != 0) ? ST_INIT : ST_IDLE;
            r_init_idx <= '0;
            r_lat_cnt  <= '0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_init_idx <= r_init_idx + 1'b1;
            end
            // WAIT spans READ_LAT-1 cycles, so the counter starts at READ_LAT-2.
            if (w_accept) begin
                r_we      <= i_req_we;
                r_err     <= w_fault;
                r_lat_cnt <= 2'((READ_LAT >= 2) ? READ_LAT - 2 : 0);
            end else if (r_state == ST_WAIT && r_lat_cnt != 2'd0) begin
                r_lat_cnt <= r_lat_cnt - 1'b1;
            end
        end
    end

    // Zero-fill sweep and accepted requests never coincide: req_ready is low in INIT.
    always_comb begin
        w_arr_we    = 1'b0;
        w_arr_re    = 1'b0;
        w_arr_idx   = w_word[IDX_W-1:0];
        w_arr_strb  = i_req_wstrb;
        w_arr_wdata = i_req_wdata;
        if (r_state == ST_INIT) begin
            w_arr_we    = 1'b1;
            w_arr_idx   = r_init_idx;
            w_arr_strb  = '1;
            w_arr_wdata = '0;
        end else if (w_accept && !w_fault && !i_rst) begin
            w_arr_we = i_req_we;
            w_arr_re = !i_req_we;
        end
    end

    sync_data_ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (w_arr_we),
        .i_re    (w_arr_re),
        .i_idx   (w_arr_idx),
        .i_wstrb (w_arr_strb),
        .i_wdata (w_arr_wdata),
        .o_rdata (w_arr_rdata)
    );

    assign o_req_ready = (r_state == ST_IDLE);
    assign o_rsp_valid = (r_state == ST_RESP);
    assign o_rsp_err   = o_rsp_valid && r_err;
    assign o_rsp_rdata = (o_rsp_valid && !r_we && !r_err) ? w_arr_rdata : '0;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sync_data_ram.sv
// Directed bench for sync_data_ram: four instances with READ_LAT 1..4, a word-level
// reference memory per instance, and an expected-response queue.
module tb_sync_data_ram;
    import sync_data_ram_pkg::*;

    localparam int NDUT = 4;

    logic        clk;
    logic        rst;
    logic        req_valid [NDUT];
    logic        req_ready [NDUT];
    logic        req_we    [NDUT];
    logic [31:0] req_addr  [NDUT];
    logic [3:0]  req_wstrb [NDUT];
    logic [31:0] req_wdata [NDUT];
    logic        rsp_valid [NDUT];
    logic        rsp_ready [NDUT];
    logic [31:0] rsp_rdata [NDUT];
    logic        rsp_err   [NDUT];
    ram_state_t  dbg_state [NDUT];

    logic [31:0] mdl [NDUT][256];
    logic [32:0] exp_q [$];

    int n_vec;
    int n_err;

    // Clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        sync_data_ram #(
            .DATA_W    (32),
            .DEPTH     (256),
            .ADDR_W    (32),
            .READ_LAT  (g + 1),
            .INIT_ZERO (1)
        ) u_dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_req_valid (req_valid[g]),
            .o_req_ready (req_ready[g]),
            .i_req_we    (req_we[g]),
            .i_req_addr  (req_addr[g]),
            .i_req_wstrb (req_wstrb[g]),
            .i_req_wdata (req_wdata[g]),
            .o_rsp_valid (rsp_valid[g]),
            .i_rsp_ready (rsp_ready[g]),
            .o_rsp_rdata (rsp_rdata[g]),
            .o_rsp_err   (rsp_err[g]),
            .o_dbg_state (dbg_state[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < NDUT; k++)
            for (int i = 0; i < 256; i++)
                mdl[k][i] = 32'h0;
    endtask

    // Called at a negedge just after rst drops; counts cycles with req_ready low.
    task automatic wait_init(input int k, input logic check_len);
        int n;
        n = 0;
        while (req_ready[k] !== 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
        if (check_len) chk("init_ready_low_cycles", 64'(n), 64'd256);
        else           chk("init_done", 64'(req_ready[k]), 64'd1);
    endtask

    // Driver + scoreboard for one transaction; starts and ends at a negedge.
    task automatic do_txn(input int k, input logic we, input logic [31:0] addr,
                          input logic [3:0] strb, input logic [31:0] wdata, input int hold);
        int n;
        int idx;
        logic fault;
        logic [32:0] exp;
        logic [32:0] got;
        n = 0;
        while (req_ready[k] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_idle", 64'(req_ready[k]), 64'd1);

        fault = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd256);
        idx   = int'(addr[9:2]);
        if (fault) begin
            exp = {1'b1, 32'h0};
        end else if (we) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[k][idx][8*b +: 8] = wdata[8*b +: 8];
            exp = {1'b0, 32'h0};
        end else begin
            exp = {1'b0, mdl[k][idx]};
        end
        exp_q.push_back(exp);

        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wstrb[k] = strb;
        req_wdata[k] = wdata;
        rsp_ready[k] = (hold == 0);
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        req_wdata[k] = $urandom;

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rsp_valid[k] !== 1'b1 && n < 20);
        chk("rsp_latency", 64'(n), 64'(k + 1));
        got = {rsp_err[k], rsp_rdata[k]};

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 64'(rsp_valid[k]), 64'd1);
            chk("bp_rsp_stable", 64'({rsp_err[k], rsp_rdata[k]}), 64'(got));
            chk("bp_req_ready", 64'(req_ready[k]), 64'd0);
        end
        rsp_ready[k] = 1'b1;

        exp = exp_q.pop_front();
        chk("rsp_rdata", 64'(got[31:0]), 64'(exp[31:0]));
        chk("rsp_err", 64'(got[32]), 64'(exp[32]));

        @(posedge clk);
        @(negedge clk);
        rsp_ready[k] = 1'b0;
        chk("rsp_valid_after_hs", 64'(rsp_valid[k]), 64'd0);
        chk("req_ready_after_hs", 64'(req_ready[k]), 64'd1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_addr[k]  = 32'h0;
            req_wstrb[k] = 4'h0;
            req_wdata[k] = 32'h0;
            rsp_ready[k] = 1'b0;
        end
        clear_model();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready[0]), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata[0]), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err[0]), 64'd0);
        chk("rst_state", 64'(dbg_state[0]), 64'(ST_INIT));
        rst = 1'b0;
        wait_init(0, 1'b1);
        for (int k = 1; k < NDUT; k++) wait_init(k, 1'b0);

        for (int k = 0; k < NDUT; k++) begin
            // Zero-filled top word, then strobed overwrite.
            do_txn(k, 1'b0, 32'h0000_03FC, 4'h0, 32'h0, 0);
            do_txn(k, 1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 0);
            do_txn(k, 1'b1, 32'h0000_0010, 4'b0010, 32'h0000_AA00, 0);
            do_txn(k, 1'b0, 32'h0000_0010, 4'h0, 32'h0, 0);
            chk("merged_word_model", 64'(mdl[k][4]), 64'hDEAD_AAEF);
            // Faults and a strobe-less write.
            do_txn(k, 1'b0, 32'h0000_0002, 4'h0, 32'h0, 0);
            do_txn(k, 1'b1, 32'h0000_0400, 4'hF, 32'hFFFF_FFFF, 0);
            do_txn(k, 1'b0, 32'h0000_0000, 4'h0, 32'h0, 0);
            do_txn(k, 1'b1, 32'h0000_0010, 4'h0, 32'h1234_5678, 0);
            do_txn(k, 1'b0, 32'h0000_0010, 4'h0, 32'h0, 0);
            // Random words, read back with and without backpressure.
            for (int r = 0; r < 3; r++) begin
                logic [31:0] a;
                a = 32'($urandom_range(0, 255)) << 2;
                do_txn(k, 1'b1, a, 4'($urandom_range(0, 15)), $urandom, 0);
                do_txn(k, 1'b0, a, 4'h0, 32'h0, (r == 0) ? 5 : 0);
            end
            do_txn(k, 1'b0, 32'h0000_0010, 4'h0, 32'h0, 5);
        end

        // Reset during WAIT on the READ_LAT=4 instance drops the write it just accepted.
        begin
            int n;
            n = 0;
            while (req_ready[3] !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            req_valid[3] = 1'b1;
            req_we[3]    = 1'b1;
            req_addr[3]  = 32'h0000_0020;
            req_wstrb[3] = 4'hF;
            req_wdata[3] = 32'h1234_5678;
            rsp_ready[3] = 1'b1;
            @(posedge clk);
            #1;
            req_valid[3] = 1'b0;
            @(negedge clk);
            chk("pre_rst_state_wait", 64'(dbg_state[3]), 64'(ST_WAIT));
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("rst_wait_rsp_valid", 64'(rsp_valid[3]), 64'd0);
            chk("rst_wait_state", 64'(dbg_state[3]), 64'(ST_INIT));
            rst = 1'b0;
            rsp_ready[3] = 1'b0;
            clear_model();
            wait_init(3, 1'b1);
            for (int k = 0; k < 3; k++) wait_init(k, 1'b0);
            do_txn(3, 1'b0, 32'h0000_0020, 4'h0, 32'h0, 0);
            do_txn(0, 1'b0, 32'h0000_0010, 4'h0, 32'h0, 0);
        end

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
